cpu_mem_bridge: RTL and testbench

- Sits between the multicycle CPU's memory port (`mem_read`/`mem_write`/`mem_byte_enable`/`mem_resp`) and a single-ported, variable-latency physical memory (`pmem_*`).
- Captures one CPU request, replays it from registers to physical memory, and returns exactly one single-cycle `mem_resp` pulse per request with registered read data.
- Lets the CPU control FSM treat every memory as "hold request until `mem_resp`", whatever the backing memory's latency.

---
 rtl/rv32i_types.sv | 17 +
 rtl/cpu_mem_bridge_watchdog.sv | 28 ++
 rtl/cpu_mem_bridge.sv | 128 ++++++++++++
 tb/tb_cpu_mem_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types plus the CPU-to-physical-memory bridge state and error constants.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_bridge_state_t;

    localparam rv32i_word      MEM_BRIDGE_ERR_DATA  = 32'hDEAD_BEEF;
    localparam rv32i_mem_wmask MEM_BRIDGE_READ_MASK = 4'b1111;
    localparam int unsigned    MEM_BRIDGE_WD_WIDTH  = 16;

endpackage

// File: rtl/cpu_mem_bridge_watchdog.sv
// Request watchdog: counts cycles spent in REQ and flags expiry on the TIMEOUT_CYCLES-th one.
module mem_bridge_watchdog
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic expired
);

    logic [MEM_BRIDGE_WD_WIDTH-1:0] count_q;

    // The count is zero on the first REQ cycle, so it reads k-1 during the k-th one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (active) begin
            count_q <= count_q + 1'b1;
        end else begin
            count_q <= '0;
        end
    end

    assign expired = active && (count_q == MEM_BRIDGE_WD_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Captures one CPU memory request, replays it to physical memory, returns one mem_resp pulse.
// Optional watchdog with sticky bridge_err is enabled by defining CPU_MEM_BRIDGE_TIMEOUT_EN.
module cpu_mem_bridge
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata,
    output logic        bridge_err
);

    mem_bridge_state_t state_q;
    rv32i_word         addr_q;
    rv32i_word         wdata_q;
    rv32i_mem_wmask    be_q;
    rv32i_word         rdata_q;
    logic              is_write_q;
    logic              resp_q;
    logic              pread_q;
    logic              pwrite_q;
    logic              expired;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
    logic err_q;

    mem_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (state_q == REQ),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == REQ && expired && !pmem_resp) begin
            err_q <= 1'b1;
        end
    end

    assign bridge_err = err_q;
`else
    assign expired    = 1'b0;
    assign bridge_err = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            resp_q     <= 1'b0;
            pread_q    <= 1'b0;
            pwrite_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write wins when the CPU raises both strobes.
                    if (mem_write) begin
                        addr_q     <= mem_address;
                        wdata_q    <= mem_wdata;
                        be_q       <= mem_byte_enable;
                        is_write_q <= 1'b1;
                        pwrite_q   <= 1'b1;
                        state_q    <= REQ;
                    end else if (mem_read) begin
                        addr_q     <= mem_address;
                        be_q       <= MEM_BRIDGE_READ_MASK;
                        is_write_q <= 1'b0;
                        pread_q    <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (pmem_resp) begin
                        if (!is_write_q) begin
                            rdata_q <= pmem_rdata;
                        end
                        pread_q  <= 1'b0;
                        pwrite_q <= 1'b0;
                        resp_q   <= 1'b1;
                        state_q  <= RESP;
                    end else if (expired) begin
                        rdata_q  <= MEM_BRIDGE_ERR_DATA;
                        pread_q  <= 1'b0;
                        pwrite_q <= 1'b0;
                        resp_q   <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                // The CPU still holds its request here; returning to IDLE skips re-capture.
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_resp         = resp_q;
    assign mem_rdata        = rdata_q;
    assign pmem_read        = pread_q;
    assign pmem_write       = pwrite_q;
    assign pmem_address     = addr_q & 32'hFFFF_FFFC;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: cycle-timeline model checked every cycle plus literal pins.
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_byte_enable = '0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp = 1'b0;
    logic [31:0] pmem_rdata = '0;
    logic        bridge_err;

    always #5 clk = ~clk;

    cpu_mem_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_byte_enable  (mem_byte_enable),
        .mem_resp         (mem_resp),
        .mem_rdata        (mem_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata),
        .bridge_err       (bridge_err)
    );

    // Expected outputs for the current cycle, written by the stimulus tasks.
    logic        check_en = 1'b0;
    logic        exp_resp = 1'b0;
    logic        exp_pread = 1'b0;
    logic        exp_pwrite = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_be = '0;

    int n_checks = 0;
    int n_fail = 0;
    int n_resp_seen = 0;
    int n_resp_exp = 0;
    int n_pwrite_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("mem_resp", 32'(mem_resp), 32'(exp_resp));
            check("pmem_read", 32'(pmem_read), 32'(exp_pread));
            check("pmem_write", 32'(pmem_write), 32'(exp_pwrite));
            check("mem_rdata", mem_rdata, exp_rdata);
            check("bridge_err", 32'(bridge_err), 32'(exp_err));
            if (exp_pread || exp_pwrite) begin
                check("pmem_address", pmem_address, exp_addr);
                check("pmem_byte_enable", 32'(pmem_byte_enable), 32'(exp_be));
                if (exp_pwrite) check("pmem_wdata", pmem_wdata, exp_wdata);
            end
            if (mem_resp) n_resp_seen++;
            if (pmem_write) n_pwrite_cycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic noise);
        for (int i = 0; i < n; i++) begin
            pmem_resp  = noise;
            pmem_rdata = $urandom;
            step();
        end
        pmem_resp = 1'b0;
    endtask

    // One CPU transaction: strobes for n cycles, pmem_resp in the n-th unless timing out.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask, input int n,
                       input logic [31:0] pdata, input logic do_resp);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = mask;
        step();
        mem_address = ~addr;
        mem_wdata   = ~wdata;
        for (int k = 1; k <= n; k++) begin
            exp_pread  = !wr;
            exp_pwrite = wr;
            exp_addr   = {addr[31:2], 2'b00};
            exp_be     = wr ? mask : 4'b1111;
            exp_wdata  = wdata;
            pmem_resp  = do_resp && (k == n);
            pmem_rdata = (k == n) ? pdata : $urandom;
            step();
        end
        pmem_resp  = 1'b0;
        exp_pread  = 1'b0;
        exp_pwrite = 1'b0;
        exp_resp   = 1'b1;
        if (!do_resp) begin
            exp_rdata = 32'hDEAD_BEEF;
            exp_err   = 1'b1;
        end else if (!wr) begin
            exp_rdata = pdata;
        end
        n_resp_exp++;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exp_resp  = 1'b0;
    endtask

    task automatic reset_now();
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        step();
        rst_n      = 1'b1;
        exp_resp   = 1'b0;
        exp_pread  = 1'b0;
        exp_pwrite = 1'b0;
        exp_err    = 1'b0;
        exp_rdata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end by %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        step();
        step();
        rst_n    = 1'b1;
        check_en = 1'b1;
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 32'h0);
        check("rst_pmem_be", 32'(pmem_byte_enable), 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        idle(2, 1'b0);

        // Zero-wait read.
        txn(1'b1, 1'b0, 32'h60, 32'h0, 4'b0000, 1, 32'h1234_5678, 1'b1);
        check("rd0_rdata", mem_rdata, 32'h1234_5678);
        check("rd0_pmem_address", pmem_address, 32'h60);
        check("rd0_pmem_be", 32'(pmem_byte_enable), 32'hF);
        idle(3, 1'b1);

        // Five-cycle write to an unaligned address.
        n_pwrite_cycles = 0;
        txn(1'b0, 1'b1, 32'h67, 32'hAABB_CCDD, 4'b1000, 5, 32'h0, 1'b1);
        check("wr_pwrite_cycles", 32'(n_pwrite_cycles), 32'd5);
        check("wr_pmem_address", pmem_address, 32'h64);
        check("wr_pmem_be", 32'(pmem_byte_enable), 32'h8);
        check("wr_rdata_kept", mem_rdata, 32'h1234_5678);
        idle(2, 1'b0);

        // Read and write together: write wins.
        txn(1'b1, 1'b1, 32'h100, 32'h0102_0304, 4'b0011, 2, 32'hFFFF_FFFF, 1'b1);
        check("both_pmem_wdata", pmem_wdata, 32'h0102_0304);
        check("both_rdata_kept", mem_rdata, 32'h1234_5678);
        idle(1, 1'b0);

        // Back-to-back reads with the new request raised the cycle after RESP.
        txn(1'b1, 1'b0, 32'h80, 32'h0, 4'b0000, 3, 32'hCAFE_F00D, 1'b1);
        txn(1'b1, 1'b0, 32'h84, 32'h0, 4'b0000, 1, 32'h5555_AAAA, 1'b1);
        check("b2b_rdata", mem_rdata, 32'h5555_AAAA);
        idle(2, 1'b0);

        // Reset while in REQ abandons the transaction.
        mem_read    = 1'b1;
        mem_address = 32'h200;
        step();
        for (int k = 0; k < 2; k++) begin
            exp_pread = 1'b1;
            exp_addr  = 32'h200;
            exp_be    = 4'b1111;
            if (k == 1) begin
                reset_now();
            end else begin
                step();
            end
        end
        check("midrst_pmem_be", 32'(pmem_byte_enable), 32'h0);
        idle(2, 1'b0);
        txn(1'b1, 1'b0, 32'h44, 32'h0, 4'b0000, 2, 32'h0BAD_CAFE, 1'b1);
        check("postrst_rdata", mem_rdata, 32'h0BAD_CAFE);
        idle(1, 1'b0);

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
        // pmem_resp on the expiry cycle is a normal completion.
        txn(1'b1, 1'b0, 32'h300, 32'h0, 4'b0000, 4, 32'h7777_0000, 1'b1);
        check("edge_no_err", 32'(bridge_err), 32'h0);
        idle(1, 1'b0);
        txn(1'b1, 1'b0, 32'h300, 32'h0, 4'b0000, 4, 32'h0, 1'b0);
        check("to_rdata", mem_rdata, 32'hDEAD_BEEF);
        idle(3, 1'b0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 1, 32'h0000_0010, 1'b1);
        idle(1, 1'b0);
        check("to_err_sticky", 32'(bridge_err), 32'h1);
        reset_now();
        check("to_err_cleared", 32'(bridge_err), 32'h0);
`else
        // Without the watchdog an unanswered request waits indefinitely.
        mem_read    = 1'b1;
        mem_address = 32'h300;
        step();
        for (int k = 0; k < 12; k++) begin
            exp_pread = 1'b1;
            exp_addr  = 32'h300;
            exp_be    = 4'b1111;
            step();
        end
        check("hang_no_err", 32'(bridge_err), 32'h0);
        check("hang_rdata", mem_rdata, 32'h0BAD_CAFE);
        reset_now();
`endif
        idle(2, 1'b0);

        check_en = 1'b0;
        check("resp_count", 32'(n_resp_seen), 32'(n_resp_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
